// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: multi-cycle AES SubBytes / InvSubBytes over a full state
// block. LANES composite-field S-box lanes (GF((2^4)^2) inversion between
// basis-change matrices) process the block beat by beat, in place.
module sub_bytes_engine #(
    parameter int unsigned NUM_BYTES = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned SBOX_PIPE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int unsigned BEATS = NUM_BYTES / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned DW    = 8 * NUM_BYTES;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    // GF(2^4) uses x^4 + x + 1; GF((2^4)^2) uses y^2 + y + LAMBDA.
    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] t;
        r = '0;
        t = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    // a^14 = a^-1 for a != 0, and maps 0 to 0.
    function automatic logic [3:0] gf4_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf4_mul(a, a);
        a4 = gf4_mul(a2, a2);
        a8 = gf4_mul(a4, a4);
        return gf4_mul(gf4_mul(a2, a4), a8);
    endfunction

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf4_mul(a[7:4], b[7:4]);
        return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
                gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
    endfunction

    // (h*y + l)^-1 = (h*d^-1)*y + (h+l)*d^-1, d = h^2*LAMBDA + h*l + l^2.
    function automatic logic [7:0] gf8_inv(input logic [7:0] a);
        logic [3:0] h, l, d, di;
        h  = a[7:4];
        l  = a[3:0];
        d  = gf4_mul(gf4_mul(h, h), LAMBDA) ^ gf4_mul(h, l) ^ gf4_mul(l, l);
        di = gf4_inv(d);
        return {gf4_mul(h, di), gf4_mul(h ^ l, di)};
    endfunction

    // Column i of a basis-change matrix lives in m[8*i +: 8].
    function automatic logic [7:0] mat_apply(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (x[i]) r = r ^ m[8*i +: 8];
        end
        return r;
    endfunction

    // Polynomial -> composite basis: columns are powers of a root of the
    // AES polynomial x^8+x^4+x^3+x+1 found in the composite field.
    function automatic logic [63:0] build_g2b();
        logic [63:0] m;
        logic [7:0]  x, x2, x3, x4, x8, beta, col;
        logic        found;
        beta  = '0;
        found = 1'b0;
        for (int unsigned c = 2; c < 256; c++) begin
            x  = 8'(c);
            x2 = gf8_mul(x, x);
            x3 = gf8_mul(x2, x);
            x4 = gf8_mul(x2, x2);
            x8 = gf8_mul(x4, x4);
            if (!found && ((x8 ^ x4 ^ x3 ^ x ^ 8'h01) == 8'h00)) begin
                beta  = x;
                found = 1'b1;
            end
        end
        m   = '0;
        col = 8'h01;
        for (int unsigned i = 0; i < 8; i++) begin
            m[8*i +: 8] = col;
            col = gf8_mul(col, beta);
        end
        return m;
    endfunction

    // Composite -> polynomial basis: column i is the preimage of unit vector i.
    function automatic logic [63:0] build_b2g(input logic [63:0] g2b);
        logic [63:0] m;
        logic [7:0]  c;
        m = '0;
        for (int unsigned p = 0; p < 256; p++) begin
            c = mat_apply(g2b, 8'(p));
            for (int unsigned i = 0; i < 8; i++) begin
                if (c == (8'h01 << i)) m[8*i +: 8] = 8'(p);
            end
        end
        return m;
    endfunction

    localparam logic [63:0] G2B = build_g2b();
    localparam logic [63:0] B2G = build_b2g(G2B);

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    endfunction

    // Input side of a lane: optional inverse affine, basis change, inversion.
    function automatic logic [7:0] lane_pre(input logic [7:0] x, input logic inv);
        return gf8_inv(mat_apply(G2B, inv ? affine_inv(x) : x));
    endfunction

    // Output side of a lane: basis change back, optional forward affine.
    function automatic logic [7:0] lane_post(input logic [7:0] y, input logic inv);
        logic [7:0] z;
        z = mat_apply(B2G, y);
        return inv ? z : affine_fwd(z);
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic            mode_q, mode_d;
    logic [BW-1:0]   beat_q, beat_d;

    logic            issue_en;
    logic            post_vld;
    logic [BW-1:0]   post_beat;
    logic [7:0]      rd_byte   [LANES];
    logic [7:0]      inv_byte  [LANES];
    logic [7:0]      post_byte [LANES];
    logic [7:0]      wr_byte   [LANES];

    // Lane inputs: pick this beat's bytes and run the inversion half.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            rd_byte[l] = '0;
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (beat_q == BW'(b)) rd_byte[l] = data_q[DW-1-8*(b*LANES+l) -: 8];
            end
            inv_byte[l] = lane_pre(rd_byte[l], mode_q);
        end
    end

    // Lane outputs: finish the substitution for the beat being written.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            wr_byte[l] = lane_post(post_byte[l], mode_q);
        end
    end

    if (SBOX_PIPE != 0) begin : g_pipe
        logic [7:0]    pipe_q [LANES];
        logic          pipe_vld_q;
        logic [BW-1:0] pipe_beat_q;

        // Issuing stops once the final beat sits in the pipe; the beat counter
        // holds at LAST meanwhile, so the drain cycle never re-issues it.
        assign issue_en  = (state_q == RUN) && !(pipe_vld_q && (pipe_beat_q == LAST));
        assign post_vld  = pipe_vld_q;
        assign post_beat = pipe_beat_q;
        assign post_byte = pipe_q;

        // Pipe register between inversion and output stage.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pipe_vld_q  <= 1'b0;
                pipe_beat_q <= '0;
                for (int unsigned l = 0; l < LANES; l++) pipe_q[l] <= '0;
            end else begin
                pipe_vld_q  <= issue_en;
                pipe_beat_q <= beat_q;
                for (int unsigned l = 0; l < LANES; l++) pipe_q[l] <= inv_byte[l];
            end
        end
    end else begin : g_comb
        assign issue_en  = (state_q == RUN);
        assign post_vld  = issue_en;
        assign post_beat = beat_q;
        assign post_byte = inv_byte;
    end

    // Next state, capture on acceptance, in-place write-back of lane results.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue_en && (beat_q != LAST)) beat_d = beat_q + 1'b1;
                if (post_vld) begin
                    for (int unsigned b = 0; b < BEATS; b++) begin
                        if (post_beat == BW'(b)) begin
                            for (int unsigned l = 0; l < LANES; l++) begin
                                data_d[DW-1-8*(b*LANES+l) -: 8] = wr_byte[l];
                            end
                        end
                    end
                    if (post_beat == LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, working register, mode flag and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench: three engine configurations (default, SBOX_PIPE=1,
// LANES=16) share stimulus; a negedge monitor checks every output block.
module tb_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   vld;
    logic [2:0]   rdy;
    logic [2:0]   ov;
    logic [2:0]   bsy;
    logic         in_mode;
    logic         out_ready;
    logic [127:0] in_data;
    logic [127:0] od [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc [3];
    int lat_exp [3] = '{4, 5, 1};
    logic [127:0] exp_q [3][$];
    logic [2:0] ov_prev = '0;

    logic [7:0] sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] inv_sbox [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_bytes_engine #(.NUM_BYTES(16), .LANES(4), .SBOX_PIPE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bsy[0]));
    sub_bytes_engine #(.NUM_BYTES(16), .LANES(4), .SBOX_PIPE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bsy[1]));
    sub_bytes_engine #(.NUM_BYTES(16), .LANES(16), .SBOX_PIPE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bsy[2]));

    function automatic logic [127:0] table_block(input logic [127:0] x, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            b = x[127-8*j -: 8];
            r[127-8*j -: 8] = inv ? inv_sbox[b] : sbox[b];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one block to all engines; each drops in_valid after its own handshake.
    task automatic send(input logic [127:0] d, input logic m, input logic [127:0] exp, input bit push);
        logic [2:0] pend;
        logic [2:0] hs;
        int n;
        if (push) for (int k = 0; k < 3; k++) exp_q[k].push_back(exp);
        in_data = d;
        in_mode = m;
        pend = 3'b111;
        vld = pend;
        n = 0;
        while (pend != 3'b000 && n < 60) begin
            hs = pend & rdy;
            tick(1);
            for (int k = 0; k < 3; k++) if (hs[k]) acc_cyc[k] = cyc;
            pend = pend & ~hs;
            vld = pend;
            n++;
        end
        if (pend != 3'b000) chk("accept_timeout", 128'(pend), 128'(0));
        vld = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || rdy != 3'b111) && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 128'(0));
    endtask

    // Monitor: latency on out_valid rise, data on each output handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && ov[k] && !ov_prev[k]) begin
                checks++;
                if (cyc - acc_cyc[k] != lat_exp[k]) begin
                    errors++;
                    $display("FAIL latency dut%0d: got %0d expected %0d", k, cyc - acc_cyc[k], lat_exp[k]);
                end
            end
            if (rst_n && ov[k] && out_ready) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output dut%0d: got %h expected none", k, od[k]);
                end else begin
                    logic [127:0] e;
                    e = exp_q[k].pop_front();
                    if (od[k] !== e) begin
                        errors++;
                        $display("FAIL out_data dut%0d: got %h expected %h", k, od[k], e);
                    end
                end
            end
        end
        ov_prev = ov;
    end

    initial begin
        logic [127:0] blk;
        logic [127:0] snap;
        int n;
        for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);

        rst_n = 1'b0;
        vld = '0;
        in_mode = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        tick(3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_ctrl%0d", k), 128'({rdy[k], ov[k], bsy[k]}), 128'(3'b100));
            chk($sformatf("reset_data%0d", k), od[k], 128'(0));
        end
        rst_n = 1'b1;
        tick(1);

        // Directed vectors in both directions.
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1);
        wait_drain();
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1);
        wait_drain();
        send(128'h000153ff000153ff000153ff000153ff, 1'b0, 128'h637ced16637ced16637ced16637ced16, 1'b1);
        send(128'h63ed63ed63ed63ed63ed63ed63ed63ed, 1'b1, 128'h00530053005300530053005300530053, 1'b1);
        wait_drain();

        // All 256 byte values, both directions, against the reference table.
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 16; b++) begin
                for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = 8'(b*16 + j);
                send(blk, m[0], table_block(blk, m[0]), 1'b1);
            end
        end
        wait_drain();

        // Back-pressure: output held, new offers ignored.
        out_ready = 1'b0;
        send(128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1);
        n = 0;
        while (ov != 3'b111 && n < 50) begin
            tick(1);
            n++;
        end
        chk("bp_all_done", 128'(ov), 128'(3'b111));
        snap = od[0];
        for (int i = 0; i < 10; i++) begin
            vld = (i % 2 == 0) ? 3'b111 : 3'b000;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_mode = ~in_mode;
            tick(1);
            chk("bp_hold", {rdy, ov, od[0][121:0]}, {3'b000, 3'b111, snap[121:0]});
        end
        vld = '0;
        out_ready = 1'b1;
        tick(1);
        chk("bp_release", 128'({rdy, ov}), 128'(6'b111000));

        // Reset during beat 2 of the default engine.
        out_ready = 1'b0;
        send(128'hffeeddccbbaa99887766554433221100, 1'b0, '0, 1'b0);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort_ctrl%0d", k), 128'({bsy[k], ov[k]}), 128'(0));
            chk($sformatf("abort_data%0d", k), od[k], 128'(0));
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(1);
        send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1);
        wait_drain();

        // Inputs churn after acceptance.
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1);
        for (int i = 0; i < 6; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_mode = ~in_mode;
            tick(1);
        end
        wait_drain();

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Multi-cycle AES SubBytes / InvSubBytes engine for a full cipher state. It accepts one state block over a valid/ready handshake and substitutes `LANES` bytes per cycle through composite-field S-box lanes, using GF((2^4)^2) inversion with basis-change matrices. It returns the substituted block over a second valid/ready handshake. It sits between the AddRoundKey and ShiftRows stages of the round datapath and supports both encrypt and decrypt direction per block.

## Interface
- `NUM_BYTES`, 16, bytes per block; must be a multiple of `LANES`.
- `LANES`, 4, parallel S-box lanes; must be ≥1 and divide `NUM_BYTES`.
- `SBOX_PIPE`, 0, 0 or 1; 1 inserts one register between GF(2^8) inversion and the output basis/affine stage of every lane.
- `clk`  input  1  clock, all state on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  block offered.
- `in_ready`  output  1  engine can accept a block.
- `in_mode`  input  1  0 = SubBytes, 1 = InvSubBytes; sampled on acceptance.
- `in_data`  input  8*NUM_BYTES  state; byte 0 = bits [8*NUM_BYTES-1 -: 8].
- `out_valid`  output  1  result available.
- `out_ready`  input  1  consumer accepts result.
- `out_data`  output  8*NUM_BYTES  substituted state, same byte order.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Per-lane function:
  - Forward: affine(inverse(x)) = FIPS-197 S-box, with inverse(0) = 0.
  - Inverse: inverse(affine⁻¹(x)).
  - Both are realised as g2b basis change → GF(2^4)-based inversion → b2g basis change, with the forward affine (constant 0x63) or inverse affine (constant 0x05) applied on the appropriate side.
  - Results must be bit-exact to the FIPS-197 tables for all 256 inputs, in both modes.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready`, capture `in_data` into the working register and `in_mode` into the mode flag, clear beat counter, go to RUN.
  - RUN: each cycle, lanes read bytes beat*LANES … beat*LANES+LANES-1 and the beat counter increments.
    - Lane results are written back in place; with `SBOX_PIPE`=1 they land one cycle later.
    - When the last beat's results are written, go to DONE.
  - DONE: `out_valid`=1 and `out_data` = working register, held stable. On `out_valid`&`out_ready`, go to IDLE.
- `in_ready` and `busy` are decoded from state only; there is no combinational path from `out_ready` to `in_ready`.
- `in_data`/`in_mode` changes outside an accepting cycle have no effect. Mode is held constant for the whole block.
- Beat counter width is clog2(NUM_BYTES/LANES), minimum 1. It wraps to 0 only via acceptance.
- `LANES`=`NUM_BYTES` gives a single beat.
- Reset (`rst_n`=0 at a rising edge), from any state including mid-RUN and DONE:
  - state goes to IDLE; working register, mode, beat counter and pipe registers clear to 0.
  - The in-flight block is discarded; no partial output is produced.
- Reset values of outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.

## Timing
- BEATS = NUM_BYTES/LANES. Let acceptance occur at edge E.
- `out_valid` rises after edge E+BEATS+SBOX_PIPE. Defaults give 4 cycles.
- `out_valid` stays high until the edge where `out_ready`=1. After that edge `in_ready`=1 and `out_valid`=0.
- Minimum block period is BEATS+SBOX_PIPE+2 cycles: accept, process, one DONE cycle, one IDLE cycle.
- `out_ready` already high when DONE is entered: handoff completes in that first DONE cycle.
- `out_ready` low: `out_data` remains unchanged indefinitely.
- With `SBOX_PIPE`=1 the final beat's pipe drain is the extra cycle; no beat overlaps a write of the same byte.

## Test plan
- Reset, then forward mode on block 193de3bea0f4e22b9ac68d2ae9f84808 -> `out_data`=d42711aee0bf98f1b8b45de51e415230; `out_valid` rises 4 cycles after acceptance (defaults).
- Same result fed back with `in_mode`=1 -> 193de3bea0f4e22b9ac68d2ae9f84808. Repeat with `SBOX_PIPE`=1 (latency 5) and `LANES`=16 (latency 1).
- Exhaustive lane check: 16 blocks covering bytes 0x00–0xFF in both modes -> match FIPS-197 tables. Spot checks: 00→63, 01→7C, 53→ED, FF→16; inverse 63→00, ED→53.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_data` stable, `in_ready`=0, and `in_valid` pulses ignored. Release -> handoff in 1 cycle, then `in_ready`=1.
- Reset mid-RUN at beat 2 -> next cycle `busy`=0, `out_valid`=0, `out_data`=0. The following block computes correctly with no residue from the aborted block.
- `in_data`/`in_mode` toggled every cycle during RUN -> result reflects only the values captured at acceptance.
